fwd_scoreboard: RTL

- Parametrised successor to the fixed MEM/WB forwarding unit.
- Tracks destination tags of in-flight instructions in NUM_FWD post-EX stages (stage 1 = MEM … stage NUM_FWD = WB). Each tag carries a result-ready countdown.
- For each of NUM_RS EX operands (rs1, rs2, store data), returns the youngest forwarding source, or raises fw_halt when that source's result is not ready yet.
- Sits beside the EX stage and drives the operand and store-data muxes and the pipeline stall/kill logic.

---
 rtl/fwd_scoreboard_pkg.sv | 22 ++
 rtl/fwd_scoreboard_if.sv | 30 +++
 rtl/fwd_scoreboard_lookup.sv | 38 +++
 rtl/fwd_scoreboard.sv | 86 ++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard: stage entry layout and select encoding.
package RVS192_package;

  localparam int REG_ADDR_W = 5;
  localparam int FW_SEL_RF  = 0;
  // Countdown field is sized for the widest supported LAT_W; narrower latencies are zero-extended.
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic [CNT_W-1:0]      cnt;
  } fwd_entry_t;

  function automatic fwd_entry_t age_entry(input fwd_entry_t e);
    fwd_entry_t r;
    r = e;
    if (e.cnt != '0) r.cnt = e.cnt - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// EX-side bundle between the pipeline (master) and the forwarding scoreboard (slave).
interface fwd_scoreboard_if #(
  parameter int NUM_RS  = 3,
  parameter int NUM_FWD = 2,
  parameter int LAT_W   = 2
);
  import RVS192_package::*;
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic                                   advance;
  logic                                   flush;
  logic [REG_ADDR_W-1:0]                  ex_rd;
  logic                                   ex_wen;
  logic [LAT_W-1:0]                       ex_lat;
  logic [NUM_RS-1:0][REG_ADDR_W-1:0]      rs_ex;
  logic [NUM_RS-1:0]                      rs_use;
  logic [NUM_RS-1:0][SEL_W-1:0]           fw_sel;
  logic                                   fw_halt;

  modport master (
    output advance, flush, ex_rd, ex_wen, ex_lat, rs_ex, rs_use,
    input  fw_sel, fw_halt
  );

  modport slave (
    input  advance, flush, ex_rd, ex_wen, ex_lat, rs_ex, rs_use,
    output fw_sel, fw_halt
  );

endinterface

// File: rtl/fwd_scoreboard_lookup.sv
// One operand channel's youngest-first tag match across all tracked post-EX stages.
module fwd_lookup
  import RVS192_package::*;
#(
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  fwd_entry_t [NUM_FWD:1]   i_stage,
  input  logic [REG_ADDR_W-1:0]    i_rs,
  input  logic                     i_use,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_halt
);

  logic [SEL_W-1:0] w_sel;
  logic             w_halt;
  logic             w_found;

  // The first match stops the search, so an older ready entry can never mask a younger pending one.
  always_comb begin
    w_sel   = SEL_W'(FW_SEL_RF);
    w_halt  = 1'b0;
    w_found = 1'b0;
    if (i_use && (i_rs != '0)) begin
      for (int k = 1; k <= NUM_FWD; k++) begin
        if (!w_found && i_stage[k].vld && (i_stage[k].rd == i_rs)) begin
          w_found = 1'b1;
          if (i_stage[k].cnt == '0) w_sel  = SEL_W'(k);
          else                      w_halt = 1'b1;
        end
      end
    end
  end

  assign o_sel  = w_sel;
  assign o_halt = w_halt;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination tags and picks operand forwarding sources.
// Optional statistics counters are enabled with `define FWD_SCOREBOARD_STAT_EN.
module fwd_scoreboard
  import RVS192_package::*;
#(
  parameter int NUM_RS  = 3,
  parameter int NUM_FWD = 2,
  parameter int LAT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fwd_scoreboard_if.slave       io_fwd
`ifdef FWD_SCOREBOARD_STAT_EN
  ,
  output logic [31:0]           o_halt_cnt,
  output logic [31:0]           o_fwd_cnt
`endif
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);

  fwd_entry_t [NUM_FWD:1]        r_stage;
  logic [NUM_RS-1:0][SEL_W-1:0]  w_sel;
  logic [NUM_RS-1:0]             w_halt_c;
  logic                          w_halt;
  logic                          w_push;
  fwd_entry_t                    w_new;

  for (genvar c = 0; c < NUM_RS; c++) begin : g_ch
    fwd_lookup #(
      .NUM_FWD (NUM_FWD),
      .SEL_W   (SEL_W)
    ) u_lookup (
      .i_stage (r_stage),
      .i_rs    (io_fwd.rs_ex[c]),
      .i_use   (io_fwd.rs_use[c]),
      .o_sel   (w_sel[c]),
      .o_halt  (w_halt_c[c])
    );
  end

  assign w_halt         = |w_halt_c;
  assign io_fwd.fw_sel  = w_sel;
  assign io_fwd.fw_halt = w_halt;

  // A halted or killed EX instruction, or one with no real destination, enters as a bubble.
  assign w_push  = !(w_halt || io_fwd.flush || !io_fwd.ex_wen || (io_fwd.ex_rd == '0));
  assign w_new   = '{vld: 1'b1, rd: io_fwd.ex_rd, cnt: CNT_W'(io_fwd.ex_lat)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else if (!io_fwd.advance) begin
      for (int k = 1; k <= NUM_FWD; k++) r_stage[k] <= age_entry(r_stage[k]);
    end else begin
      for (int k = 2; k <= NUM_FWD; k++) r_stage[k] <= age_entry(r_stage[k-1]);
      r_stage[1] <= w_push ? w_new : '0;
    end
  end

  // An entry must be ready before it leaves the last tracked stage, otherwise its result is lost.
  a_retire_ready: assert property (@(posedge clk) disable iff (rst)
    !(io_fwd.advance && r_stage[NUM_FWD].vld && (r_stage[NUM_FWD].cnt != '0)));

`ifdef FWD_SCOREBOARD_STAT_EN
  logic [31:0] r_halt_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_any_fwd;

  assign w_any_fwd = |w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt_cnt <= '0;
      r_fwd_cnt  <= '0;
    end else begin
      if (w_halt && io_fwd.advance && (r_halt_cnt != '1)) r_halt_cnt <= r_halt_cnt + 1'b1;
      if (w_any_fwd && !w_halt && (r_fwd_cnt != '1))     r_fwd_cnt  <= r_fwd_cnt + 1'b1;
    end
  end

  assign o_halt_cnt = r_halt_cnt;
  assign o_fwd_cnt  = r_fwd_cnt;
`endif

endmodule
